spi_bus_bridge: RTL
===================

# spi_bus_bridge

Parametrised SPI-packet to Xosera parallel-bus bridge. It sits between `spi_target` (byte strobes in the `clk` domain) and `xosera_main`'s 8-bit register bus, replacing ad-hoc inline glue in the board top. Each packet is a command byte followed by one or more payload bytes. Each payload byte produces one fixed-width bus cycle. Read data is registered and returned on the following SPI byte.

## Interface
- `HOLD_CYCLES`, default 2: cycles `bus_cs_n_o` stays asserted per bus cycle; legal range 1–15.
- `IDLE_BYTE`, default 8'hCB: value on `transmit_byte_o` when no read data is pending.
- `clk` in, 1: pixel clock; the block's only clock.
- `reset_n_i` in, 1: synchronous, active-low reset.
- `select_i` in, 1: SPI peripheral selected, from `spi_target`.
- `receive_strobe_i` in, 1: one-cycle pulse; `receive_byte_i` is valid.
- `receive_byte_i` in, 8: received SPI byte.
- `transmit_byte_o` out, 8: byte for the next SPI shift-out.
- `bus_cs_n_o` out, 1: bus select, active low.
- `bus_rd_nwr_o` out, 1: 1 = read, 0 = write.
- `bus_bytesel_o` out, 1: 0 = even byte, 1 = odd byte.
- `bus_reg_num_o` out, 4: register number.
- `bus_data_o` out, 8: write data to `xosera_main.bus_data_i`.
- `bus_data_i` in, 8: read data from `xosera_main.bus_data_o`.
- `soft_reset_o` out, 1: one-cycle soft-reset pulse.
- `busy_o` out, 1: a bus cycle is in progress.
- `overrun_o` out, 1: sticky flag; a byte was lost.

## Operation
- Command byte bits: [7] CS, [6] WR, [5] RS, [4] BS, [3:0] REG.
- States:
  - CMD: the next strobe is a command byte.
  - PAYLOAD: waiting for a payload byte.
  - BUS: `bus_cs_n_o` is asserted and a down-counter is running.
- CMD + strobe:
  - Latch the command byte and go to PAYLOAD.
  - If RS is set, pulse `soft_reset_o` on the next cycle; the command is otherwise processed normally.
- PAYLOAD + strobe:
  - Latch `bus_data_o` from the byte.
  - If CS=1, load the counter with `HOLD_CYCLES` and go to BUS.
  - If CS=0, no bus cycle occurs; next state is CMD (or stays PAYLOAD in burst mode).
- BUS:
  - `bus_rd_nwr_o` is ~WR.
  - `bus_reg_num_o` is REG.
  - `bus_bytesel_o` is the current byte-select.
  - On the last CS-low cycle, capture `bus_data_i` into the read register.
  - On exit, go to CMD (or PAYLOAD in burst mode).
- `transmit_byte_o`:
  - Shows the read register from the cycle after BUS exits until the next payload strobe.
  - Shows `IDLE_BYTE` otherwise, including after writes.
- Strobe arriving during BUS:
  - Held in a one-entry pending register and processed on BUS exit.
  - A second strobe while an entry is pending is dropped and sets `overrun_o`.
  - `overrun_o` clears only on reset.
- `select_i` deasserted:
  - Next state is CMD and the pending entry is discarded.
  - An active bus cycle always completes its full `HOLD_CYCLES`; bus cycles are never truncated.

## Timing
- Reset values:
  - `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_bytesel_o`=0.
  - `bus_reg_num_o`=0, `bus_data_o`=0.
  - `transmit_byte_o`=`IDLE_BYTE`.
  - `soft_reset_o`=0, `busy_o`=0, `overrun_o`=0.
  - State = CMD.
- Payload strobe at cycle T:
  - `bus_cs_n_o` is low for cycles T+1 .. T+`HOLD_CYCLES`.
  - Address, control and data outputs are stable from T+1 through T+`HOLD_CYCLES`+1.
  - `busy_o` is high during the same window as `bus_cs_n_o` low.
- Read data is sampled at edge T+`HOLD_CYCLES`; `transmit_byte_o` is valid at T+`HOLD_CYCLES`+1.
- Back-to-back: the minimum spacing between payload strobes without pending-register use is `HOLD_CYCLES`+1.
- Reset asserted mid-BUS: all outputs take reset values at the next edge.

## Configuration
- `SPI_BRIDGE_BURST_EN` defined:
  - After each payload byte, stay in PAYLOAD while `select_i` is high.
  - `bus_bytesel_o` starts at BS and toggles after every bus cycle, so a 16-bit word or a stream fits in one packet.
  - REG is unchanged across the burst.
- `SPI_BRIDGE_BURST_EN` undefined:
  - Exactly one payload byte per command.
  - Further bytes are treated as a new command.

## Structure
- In `xv`:
  - Command-bit index localparams: `SPI_CMD_CS`, `SPI_CMD_WR`, `SPI_CMD_RS`, `SPI_CMD_BS`, `SPI_CMD_REG_LSB`.
  - `typedef enum logic [1:0] {SPI_CMD, SPI_PAYLOAD, SPI_BUS} spi_bridge_st_t`.
  - Default `IDLE_BYTE`.
- No sub-module. `spi_target` stays separate and is instantiated beside this block in the board top.

## Test plan
- Write:
  - Stimulus: strobes 8'hC3 then 8'h5A, `HOLD_CYCLES`=2.
  - Required: `bus_cs_n_o` low exactly 2 cycles; reg=3, `rd_nwr`=0, `bytesel`=0, data=8'h5A stable through T+3.
- Read:
  - Stimulus: strobes 8'h91 then 8'h00, with `bus_data_i`=8'hA7.
  - Required: `rd_nwr`=1, `bytesel`=1, reg=1; `transmit_byte_o`=8'hA7 at T+3, and `IDLE_BYTE` after the next payload strobe.
- Soft reset:
  - Stimulus: command 8'h20.
  - Required: `soft_reset_o` high exactly one cycle; no bus cycle after the payload.
- Burst (`SPI_BRIDGE_BURST_EN`):
  - Stimulus: 8'hC0 then 8'h12, 8'h34, 8'h56.
  - Required: three bus cycles with `bytesel` 0,1,0.
- Overrun:
  - Stimulus: three strobes within one BUS window.
  - Required: the first is processed after BUS exits, the second is dropped, and `overrun_o`=1.
- Disruptions:
  - `select_i` dropped mid-BUS: the bus cycle still lasts the full `HOLD_CYCLES`, then state = CMD.
  - Reset mid-BUS: `bus_cs_n_o`=1 at the next edge.

Source files
------------

// File: rtl/xv_pkg.sv
// Shared definitions for the SPI-to-Xosera bus bridge: command-byte layout,
// bridge FSM states and bus request record.
package xv;

    localparam int SPI_CMD_CS      = 7;
    localparam int SPI_CMD_WR      = 6;
    localparam int SPI_CMD_RS      = 5;
    localparam int SPI_CMD_BS      = 4;
    localparam int SPI_CMD_REG_LSB = 0;

    localparam logic [7:0] SPI_IDLE_BYTE_DEFAULT = 8'hCB;

    typedef enum logic [1:0] {
        SPI_CMD,
        SPI_PAYLOAD,
        SPI_BUS
    } spi_bridge_st_t;

    // Command byte fields kept after the command strobe; RS acts immediately
    // and BS seeds the running byte-select, so neither is stored here.
    typedef struct packed {
        logic       cs;
        logic       wr;
        logic [3:0] reg_num;
    } spi_cmd_t;

    typedef struct packed {
        logic       rd_nwr;
        logic       bytesel;
        logic [3:0] reg_num;
        logic [7:0] data;
    } spi_bus_req_t;

    localparam spi_bus_req_t SPI_BUS_REQ_RESET = '{
        rd_nwr:  1'b1,
        bytesel: 1'b0,
        reg_num: 4'h0,
        data:    8'h00
    };

    function automatic spi_cmd_t spi_decode_cmd(input logic [7:0] cmd_byte);
        spi_cmd_t c;
        c.cs      = cmd_byte[SPI_CMD_CS];
        c.wr      = cmd_byte[SPI_CMD_WR];
        c.reg_num = cmd_byte[SPI_CMD_REG_LSB +: 4];
        return c;
    endfunction

endpackage

// File: rtl/spi_bus_bridge.sv
// Turns SPI packets (command byte + payload bytes) into fixed-length Xosera
// register-bus cycles. Define SPI_BRIDGE_BURST_EN for multi-byte packets.
module spi_bus_bridge
    import xv::*;
#(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       select_i,
    input  logic       receive_strobe_i,
    input  logic [7:0] receive_byte_i,
    output logic [7:0] transmit_byte_o,
    output logic       bus_cs_n_o,
    output logic       bus_rd_nwr_o,
    output logic       bus_bytesel_o,
    output logic [3:0] bus_reg_num_o,
    output logic [7:0] bus_data_o,
    input  logic [7:0] bus_data_i,
    output logic       soft_reset_o,
    output logic       busy_o,
    output logic       overrun_o
);

`ifdef SPI_BRIDGE_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    // Handshake: receive_strobe_i is a one-cycle valid with no ready. A byte
    // that cannot be taken at once waits in a single pending slot; a byte
    // arriving while that slot is full is lost and raises overrun_o.

    spi_bridge_st_t state, state_next;

    spi_cmd_t     cmd_q;
    logic         bytesel_q;
    logic [3:0]   hold_cnt;
    logic         pend_valid;
    logic [7:0]   pend_byte;
    logic         rd_valid;
    logic [7:0]   rd_data_q;
    logic         drop_q;
    spi_bus_req_t bus_q;
    logic         soft_reset_q;
    logic         overrun_q;

    logic         take;
    logic [7:0]   in_byte;
    logic         last_cycle;

    // A pending byte is always older than a live strobe, so it goes first.
    assign in_byte    = pend_valid ? pend_byte : receive_byte_i;
    assign take       = select_i && (state != SPI_BUS) && (pend_valid || receive_strobe_i);
    assign last_cycle = (state == SPI_BUS) && (hold_cnt == 4'd1);

    always_comb begin
        state_next = state;
        case (state)
            SPI_CMD: begin
                if (!select_i) begin
                    state_next = SPI_CMD;
                end else if (take) begin
                    state_next = SPI_PAYLOAD;
                end
            end
            SPI_PAYLOAD: begin
                if (!select_i) begin
                    state_next = SPI_CMD;
                end else if (take) begin
                    if (cmd_q.cs) begin
                        state_next = SPI_BUS;
                    end else begin
                        state_next = BURST_EN ? SPI_PAYLOAD : SPI_CMD;
                    end
                end
            end
            SPI_BUS: begin
                // A deselect seen anywhere in the window ends the packet.
                if (last_cycle) begin
                    state_next = (BURST_EN && select_i && !drop_q) ? SPI_PAYLOAD : SPI_CMD;
                end
            end
            default: state_next = SPI_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state        <= SPI_CMD;
            cmd_q        <= '0;
            bytesel_q    <= 1'b0;
            hold_cnt     <= '0;
            pend_valid   <= 1'b0;
            pend_byte    <= '0;
            rd_valid     <= 1'b0;
            rd_data_q    <= '0;
            drop_q       <= 1'b0;
            bus_q        <= SPI_BUS_REQ_RESET;
            soft_reset_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= state_next;
            soft_reset_q <= take && (state == SPI_CMD) && in_byte[SPI_CMD_RS];

            if (take && (state == SPI_CMD)) begin
                cmd_q     <= spi_decode_cmd(in_byte);
                bytesel_q <= in_byte[SPI_CMD_BS];
            end

            if (take && (state == SPI_PAYLOAD)) begin
                rd_valid <= 1'b0;
                if (cmd_q.cs) begin
                    hold_cnt <= 4'(HOLD_CYCLES);
                    bus_q    <= '{
                        rd_nwr:  ~cmd_q.wr,
                        bytesel: bytesel_q,
                        reg_num: cmd_q.reg_num,
                        data:    in_byte
                    };
                end else begin
                    bus_q.data <= in_byte;
                end
            end

            if (state == SPI_BUS) begin
                hold_cnt <= hold_cnt - 4'd1;
                if (!select_i) begin
                    drop_q <= 1'b1;
                end
                if (last_cycle) begin
                    rd_data_q <= bus_data_i;
                    rd_valid  <= bus_q.rd_nwr;
                    bytesel_q <= ~bytesel_q;
                    drop_q    <= 1'b0;
                end
            end

            if (!select_i) begin
                pend_valid <= 1'b0;
            end else if (state == SPI_BUS) begin
                if (receive_strobe_i) begin
                    if (pend_valid) begin
                        overrun_q <= 1'b1;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_byte  <= receive_byte_i;
                    end
                end
            end else if (pend_valid) begin
                // The slot drains this cycle; a live strobe takes its place.
                if (receive_strobe_i) begin
                    pend_byte <= receive_byte_i;
                end else begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end

    assign bus_cs_n_o      = (state != SPI_BUS);
    assign busy_o          = (state == SPI_BUS);
    assign bus_rd_nwr_o    = bus_q.rd_nwr;
    assign bus_bytesel_o   = bus_q.bytesel;
    assign bus_reg_num_o   = bus_q.reg_num;
    assign bus_data_o      = bus_q.data;
    assign transmit_byte_o = rd_valid ? rd_data_q : IDLE_BYTE;
    assign soft_reset_o    = soft_reset_q;
    assign overrun_o       = overrun_q;

endmodule
